// File: rtl/rv32_mod_instruction_fetch.sv
// Word fetch into a halfword queue, realigned into 16/32-bit instructions tagged with PC and fault.
// Ack at cycle N is visible at N+1; fetch stalls below 2 free entries, output holds while instr_ready=0.
module rv32_mod_instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          HW_DEPTH = 6
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_is_compressed,
   output logic        instr_fault
);

   localparam int PW = $clog2(HW_DEPTH);
   localparam int CW = $clog2(HW_DEPTH + 1);
   localparam logic [31:0]   START_PC = RESET_PC & ~32'h1;
   localparam logic [CW-1:0] FREE_LIM = CW'(HW_DEPTH - 2);

   typedef struct packed {
      logic        flt;
      logic [15:0] dat;
   } hw_t;

   hw_t           q_mem [HW_DEPTH];
   logic [PW-1:0] head, tail, head_p1, tail_p1, head_nxt, tail_nxt;
   logic [CW-1:0] count, count_nxt;
   logic [31:0]   fetch_pc, req_addr;
   logic          req_hold, halted, drop, skip_low, boot;
   logic          ack_v, do_push, pop_all, out_vld, out_flt, xfer;
   logic [1:0]    push_n, pop_n;
   logic [31:0]   out_ins;
   hw_t           h0, h1;

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
      logic [PW:0] s;
      s = {1'b0, p} + {{(PW-1){1'b0}}, n};
      if (s >= (PW+1)'(HW_DEPTH)) s = s - (PW+1)'(HW_DEPTH);
      return s[PW-1:0];
   endfunction

   // A held request keeps its latched address even across a redirect.
   assign imem_req  = ~boot & (req_hold | (~halted & (count <= FREE_LIM)));
   assign imem_addr = req_hold ? req_addr : {fetch_pc[31:2], 2'b00};
   assign ack_v     = imem_ack & imem_req;
   assign do_push   = ack_v & ~drop & ~redirect_valid;
   assign push_n    = !do_push ? 2'd0 : (skip_low ? 2'd1 : 2'd2);

   assign head_p1 = ptr_add(head, 2'd1);
   assign tail_p1 = ptr_add(tail, 2'd1);
   assign h0      = q_mem[head];
   assign h1      = q_mem[head_p1];

   always_comb begin
      out_vld = 1'b0;
      out_flt = 1'b0;
      out_ins = 32'h0;
      pop_n   = 2'd0;
      pop_all = 1'b0;
      if (count != {CW{1'b0}}) begin
         if (h0.flt) begin
            out_vld = 1'b1;
            out_flt = 1'b1;
            pop_all = 1'b1;
         end else if (h0.dat[1:0] != 2'b11) begin
            out_vld = 1'b1;
            out_ins = {16'h0, h0.dat};
            pop_n   = 2'd1;
         end else if (count >= CW'(2)) begin
            out_vld = 1'b1;
            if (h1.flt) begin
               out_flt = 1'b1;
               pop_all = 1'b1;
            end else begin
               out_ins = {h1.dat, h0.dat};
               pop_n   = 2'd2;
            end
         end
      end
   end

   assign instr_valid         = out_vld & ~redirect_valid;
   assign instruction         = out_ins;
   assign instr_fault         = out_flt & instr_valid;
   assign instr_is_compressed = instr_valid & (out_ins[1:0] != 2'b11);
   assign xfer                = instr_valid & instr_ready;

   // A faulted instruction discards everything queued behind it.
   always_comb begin
      head_nxt  = head;
      count_nxt = count + {{(CW-2){1'b0}}, push_n};
      if (xfer && pop_all) begin
         head_nxt  = tail;
         count_nxt = {{(CW-2){1'b0}}, push_n};
      end else if (xfer) begin
         head_nxt  = ptr_add(head, pop_n);
         count_nxt = count - {{(CW-2){1'b0}}, pop_n} + {{(CW-2){1'b0}}, push_n};
      end
      tail_nxt = ptr_add(tail, push_n);
   end

   always_ff @(posedge clk) begin
      if (push_n != 2'd0) begin
         q_mem[tail] <= '{flt: imem_err, dat: (skip_low ? imem_rdata[31:16] : imem_rdata[15:0])};
         if (push_n == 2'd2) q_mem[tail_p1] <= '{flt: imem_err, dat: imem_rdata[31:16]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         fetch_pc <= START_PC;
         instr_pc <= START_PC;
         req_addr <= {START_PC[31:2], 2'b00};
         req_hold <= 1'b0;
         halted   <= 1'b0;
         drop     <= 1'b0;
         skip_low <= START_PC[1];
         boot     <= 1'b1;
      end else begin
         boot     <= 1'b0;
         req_hold <= imem_req & ~imem_ack;
         if (imem_req && !imem_ack) req_addr <= imem_addr;
         if (redirect_valid) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc & ~32'h1;
            instr_pc <= redirect_pc & ~32'h1;
            halted   <= 1'b0;
            skip_low <= redirect_pc[1];
            drop     <= imem_req & ~imem_ack;
         end else begin
            if (ack_v && drop) begin
               drop <= 1'b0;
            end else if (ack_v) begin
               fetch_pc <= fetch_pc + 32'd4;
               skip_low <= 1'b0;
               if (imem_err) halted <= 1'b1;
            end
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            if (xfer) instr_pc <= instr_pc + (instr_is_compressed ? 32'd2 : 32'd4);
         end
      end
   end

endmodule
